// File: rtl/data_memory_responder.sv
// Word-addressed data memory responder: one request at a time, stalls for LATENCY cycles, acks with a pulse.
// Optional feature: define DMEM_ADDR_CHECK_EN to flag misaligned / out-of-range addresses on err_o.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic              accept;
  logic              access;
  logic              acc_we;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_err;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state == IDLE) && req_i;
  // The access fires on the edge that enters RESP; a reset on that edge cancels it.
  assign access = (state_nxt == RESP) && !rst_i;

  // With LATENCY=1 the access happens on the accept edge, so it must see the live inputs.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = we_i;
      acc_idx   = addr_i[IDX_W+1:2];
      acc_wdata = wdata_i;
    end else begin
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
    end
  end

`ifdef DMEM_ADDR_CHECK_EN
  logic addr_err;
  logic err_q;

  assign addr_err = (addr_i[1:0] != 2'b00) || (addr_i[31:IDX_W+2] != '0);
  assign acc_err  = (state == IDLE) ? addr_err : err_q;

  always_ff @(posedge clk_i) begin
    if (accept) err_q <= addr_err;
  end
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[1:0], addr_i[31:IDX_W+2]};
  assign acc_err          = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall_o = accept || (state == WAIT);
    ack_o   = (state == RESP);
`ifdef DMEM_ADDR_CHECK_EN
    err_o   = (state == RESP) && err_q;
`else
    err_o   = 1'b0;
`endif
  end

  // NOTE: request latches and the wait counter carry no reset; they are always written on accept before use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= we_i;
      idx_q   <= addr_i[IDX_W+1:2];
      wdata_q <= wdata_i;
      cnt     <= 4'(LATENCY - 2);
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt     <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (access && !acc_we) begin
      rdata_o <= acc_err ? 32'h0 : mem[acc_idx];
    end
  end

  // NOTE: the array is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (access && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
  end

endmodule
